// File: rtl/mem_word_requester_if.sv
// Command and halfword-memory signals of mem_word_requester, bundled as one interface.
// slave = the requester's view; master = pipeline plus memHandler side.
interface mem_word_requester_if;
    logic        cmd_read;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [15:0] mem_value;
    logic        mem_lb;
    logic        mem_hb;
    logic        mem_blocked;
    logic [15:0] mem_rdata;

    modport slave (
        input  cmd_read, cmd_write, cmd_addr, cmd_wdata, mem_blocked, mem_rdata,
        output busy, done, rdata, err, mem_read, mem_write, mem_addr, mem_value,
               mem_lb, mem_hb
    );

    modport master (
        output cmd_read, cmd_write, cmd_addr, cmd_wdata, mem_blocked, mem_rdata,
        input  busy, done, rdata, err, mem_read, mem_write, mem_addr, mem_value,
               mem_lb, mem_hb
    );
endinterface

// File: rtl/mem_word_requester.sv
// Splits a 32-bit load/store into two little-endian halfword requests to memHandler
// port 2, holding each against back-pressure, with a per-half blocked-cycle watchdog.
//
//   state  | meaning
//   IDLE   | waiting for a command
//   LO     | requesting low half at addr
//   HI     | requesting high half at addr+2
//   DONE   | one-cycle completion pulse
//   ERR    | one-cycle error pulse (bad command or watchdog abort)
module mem_word_requester #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 CLOCK_50,
    input logic                 reset,
    mem_word_requester_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;

    logic        in_req;
    logic        bad_cmd;
    logic        any_cmd;
    logic        wd_expired;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            rdata_q    <= '0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            rdata_q    <= rdata_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    assign any_cmd    = bus.cmd_read | bus.cmd_write;
    assign bad_cmd    = (bus.cmd_read & bus.cmd_write) | (any_cmd & bus.cmd_addr[0]);
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        rdata_d    = rdata_q;
        wd_cnt_d   = wd_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bad_cmd) begin
                    state_d = S_ERR;
                end else if (any_cmd) begin
                    state_d    = S_LO;
                    is_write_d = bus.cmd_write;
                    addr_d     = bus.cmd_addr;
                    wdata_d    = bus.cmd_wdata;
                    wd_cnt_d   = '0;
                end
            end
            S_LO: begin
                if (!bus.mem_blocked) begin
                    state_d  = S_HI;
                    wd_cnt_d = '0;
                    if (!is_write_q) lo_d = bus.mem_rdata;
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            S_HI: begin
                if (!bus.mem_blocked) begin
                    state_d = S_DONE;
                    // rdata only changes at completion, so the low half waits in lo_q
                    if (!is_write_q) rdata_d = {bus.mem_rdata, lo_q};
                end else if (wd_expired) begin
                    state_d = S_ERR;
                end else begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_req        = (state_q == S_LO) || (state_q == S_HI);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = (state_q == S_ERR);
    assign bus.rdata     = rdata_q;
    assign bus.mem_read  = in_req & ~is_write_q;
    assign bus.mem_write = in_req & is_write_q;
    assign bus.mem_lb    = in_req;
    assign bus.mem_hb    = in_req;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_value = '0;
        if (state_q == S_LO) begin
            bus.mem_addr  = addr_q;
            bus.mem_value = wdata_q[15:0];
        end else if (state_q == S_HI) begin
            bus.mem_addr  = addr_q + 32'd2;
            bus.mem_value = wdata_q[31:16];
        end
    end

endmodule

// File: tb/tb_mem_word_requester.sv
// Bench for mem_word_requester: plays the pipeline and a halfword memory handler,
// predicting every cycle from a per-command phase list and a word-level memory model.
module tb_mem_word_requester;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_word_requester_if bus();

    mem_word_requester #(.TIMEOUT(TO)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    typedef enum {P_LO, P_HI, P_DONE, P_ERR} ph_t;
    typedef struct {
        ph_t ph;
        bit  blk;
    } step_t;

    int total = 0;
    int bad   = 0;

    logic [15:0] hmem [logic [31:0]];
    logic [15:0] mmem [logic [31:0]];
    logic [31:0] exp_rdata = '0;

    function automatic logic [15:0] dflt(logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] hrd(logic [31:0] a);
        return hmem.exists(a) ? hmem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] mrd(logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : dflt(a);
    endfunction

    function automatic step_t mk(ph_t p, bit b);
        step_t s;
        s.ph  = p;
        s.blk = b;
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_err"},   32'(bus.err), 0);
        chk({tag, "_mrd"},   32'(bus.mem_read), 0);
        chk({tag, "_mwr"},   32'(bus.mem_write), 0);
        chk({tag, "_lanes"}, 32'({bus.mem_lb, bus.mem_hb}), 0);
    endtask

    // Issue one command at the current negedge and follow it until IDLE again.
    task automatic txn(bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                       int blo, int bhi, bit rst_in_hi);
        step_t       q[$];
        step_t       st;
        logic [31:0] a2;
        logic [31:0] e_addr;
        logic [15:0] e_val;
        bit          req;
        a2 = a + 32'd2;
        chk("pre_busy", 32'(bus.busy), 0);
        bus.cmd_read    = rd;
        bus.cmd_write   = wr;
        bus.cmd_addr    = a;
        bus.cmd_wdata   = wd;
        bus.mem_blocked = 1'($urandom);
        if (!(rd || wr)) begin
            @(negedge clk);
            chk_quiet("noop");
            return;
        end
        if ((rd && wr) || a[0]) begin
            q.push_back(mk(P_ERR, 1'b0));
        end else begin
            if (blo >= TO) begin
                repeat (TO) q.push_back(mk(P_LO, 1'b1));
                q.push_back(mk(P_ERR, 1'b0));
            end else begin
                repeat (blo) q.push_back(mk(P_LO, 1'b1));
                q.push_back(mk(P_LO, 1'b0));
                if (bhi >= TO) begin
                    repeat (TO) q.push_back(mk(P_HI, 1'b1));
                    q.push_back(mk(P_ERR, 1'b0));
                end else begin
                    repeat (bhi) q.push_back(mk(P_HI, 1'b1));
                    q.push_back(mk(P_HI, 1'b0));
                    q.push_back(mk(P_DONE, 1'b0));
                end
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            st  = q[i];
            req = (st.ph == P_LO) || (st.ph == P_HI);
            if (i == q.size() - 1) begin
                bus.cmd_read  = 1'b0;
                bus.cmd_write = 1'b0;
            end else begin
                bus.cmd_read  = 1'($urandom);
                bus.cmd_write = 1'($urandom);
                bus.cmd_addr  = $urandom;
                bus.cmd_wdata = $urandom;
            end
            e_addr = (st.ph == P_LO) ? a : (st.ph == P_HI) ? a2 : 32'd0;
            e_val  = (st.ph == P_LO) ? wd[15:0] : (st.ph == P_HI) ? wd[31:16] : 16'd0;
            if (st.ph == P_DONE && rd) exp_rdata = {mrd(a2), mrd(a)};
            chk("busy",  32'(bus.busy), 1);
            chk("done",  32'(bus.done), 32'(st.ph == P_DONE));
            chk("err",   32'(bus.err), 32'(st.ph == P_ERR));
            chk("mrd",   32'(bus.mem_read), 32'(req && rd));
            chk("mwr",   32'(bus.mem_write), 32'(req && wr));
            chk("lanes", 32'({bus.mem_lb, bus.mem_hb}), req ? 32'd3 : 32'd0);
            chk("maddr", bus.mem_addr, e_addr);
            chk("mval",  32'(bus.mem_value), 32'(e_val));
            chk("rdata", bus.rdata, exp_rdata);
            if (rst_in_hi && st.ph == P_HI) begin
                rst           = 1'b1;
                bus.cmd_read  = 1'b0;
                bus.cmd_write = 1'b0;
                @(negedge clk);
                exp_rdata = '0;
                chk_quiet("rst_hi");
                chk("rst_hi_maddr", bus.mem_addr, 0);
                chk("rst_hi_mval",  32'(bus.mem_value), 0);
                chk("rst_hi_rdata", bus.rdata, exp_rdata);
                rst = 1'b0;
                return;
            end
            bus.mem_rdata = 16'($urandom);
            if (req && !st.blk) begin
                bus.mem_blocked = 1'b0;
                if (bus.mem_write) hmem[bus.mem_addr] = bus.mem_value;
                if (bus.mem_read)  bus.mem_rdata = hrd(bus.mem_addr);
                if (wr) mmem[e_addr] = e_val;
            end else begin
                bus.mem_blocked = req ? 1'b1 : 1'($urandom);
            end
        end
        @(negedge clk);
        chk_quiet("post");
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        rst             = 1'b1;
        bus.cmd_read    = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.mem_blocked = 1'b0;
        bus.mem_rdata   = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset_maddr", bus.mem_addr, 0);
        chk("reset_mval",  32'(bus.mem_value), 0);
        chk("reset_rdata", bus.rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        hmem[32'h100] = 16'hBEEF;  mmem[32'h100] = 16'hBEEF;
        hmem[32'h102] = 16'hDEAD;  mmem[32'h102] = 16'hDEAD;
        txn(1, 0, 32'h0000_0100, $urandom, 0, 0, 0);
        chk("tp_load_word", bus.rdata, 32'hDEADBEEF);

        txn(0, 1, 32'h0000_0200, 32'h1234_5678, 3, 0, 0);
        txn(1, 0, 32'h0000_0200, $urandom, 0, 1, 0);
        chk("tp_store_readback", bus.rdata, 32'h1234_5678);

        txn(1, 0, 32'h0000_0201, $urandom, 0, 0, 0);
        txn(1, 1, 32'h0000_0300, $urandom, 0, 0, 0);
        txn(0, 1, 32'h0000_0303, $urandom, 0, 0, 0);

        txn(1, 0, 32'h0000_0100, $urandom, 10, 0, 0);
        txn(1, 0, 32'h0000_0100, $urandom, 0, 0, 0);
        txn(1, 0, 32'h0000_0200, $urandom, TO, 0, 0);
        txn(1, 0, 32'h0000_0200, $urandom, TO - 1, TO - 1, 0);
        txn(0, 1, 32'h0000_0400, 32'hCAFE_F00D, 0, 6, 0);
        txn(1, 0, 32'h0000_0400, $urandom, 0, 0, 0);

        txn(1, 0, 32'h0000_0102, $urandom, 0, 0, 1);
        txn(1, 0, 32'h0000_0100, $urandom, 0, 0, 0);
        chk("tp_after_reset", bus.rdata, 32'hDEADBEEF);

        txn(1, 0, 32'hFFFF_FFFE, $urandom, 0, 0, 0);
        txn(0, 1, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1, 1, 0);
        txn(1, 0, 32'hFFFF_FFFE, $urandom, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       a = 32'h0000_0100;
                1:       a = 32'h0000_0200;
                2:       a = 32'h8000_0010;
                default: a = 32'hFFFF_FFFE;
            endcase
            if (r == 0)      txn(1, 1, a, $urandom, 0, 0, 0);
            else if (r == 1) txn(1'($urandom), 1'($urandom), a | 32'd1, $urandom, 0, 0, 0);
            else if (r == 2) txn(0, 0, a, $urandom, 0, 0, 0);
            else if (r < 6)  txn(0, 1, a, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), 0);
            else             txn(1, 0, a, $urandom, $urandom_range(0, 5), $urandom_range(0, 5), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_word_requester.md
# mem_word_requester

Initiator-side adapter between the pipeline's memory stage and port 2 of `memHandler`. Accepts one 32-bit load or store per command, splits it into two 16-bit halfword transactions (low half at `addr`, high half at `addr+2`, little-endian), holds each request against the handler's `blocked` back-pressure, and reassembles read data. A watchdog aborts a half that stays blocked too long.

## Interface
- `TIMEOUT`, 255: max consecutive blocked cycles per half before abort; 0 disables the watchdog.
- `CLOCK_50`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_read`  in  1  start a 32-bit load; sampled only in IDLE.
- `cmd_write`  in  1  start a 32-bit store; sampled only in IDLE.
- `cmd_addr`  in  32  byte address; bit 0 must be 0.
- `cmd_wdata`  in  32  store data.
- `busy`  out  1  command in flight (state ≠ IDLE); memory stage stalls on it.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result; valid while `done`=1, held until next completion.
- `err`  out  1  one-cycle pulse: misaligned, conflicting or timed-out command.
- `mem_read`  out  1  halfword read request to handler.
- `mem_write`  out  1  halfword write request to handler.
- `mem_addr`  out  32  byte address of current half.
- `mem_value`  out  16  write halfword.
- `mem_lb`, `mem_hb`  out  1 each  byte-lane enables; both 1 during any request.
- `mem_blocked`  in  1  handler not granting this cycle.
- `mem_rdata`  in  16  read halfword; valid in the granting cycle.

## Operation
- States: IDLE, LO, HI, DONE, ERR.
- IDLE: if exactly one of `cmd_read`/`cmd_write` is 1 and `cmd_addr[0]`=0 → latch op, addr, wdata; go LO. Both set, or `cmd_addr[0]`=1 with either set → go ERR, no memory access. Neither set → stay.
- LO: drive request with `mem_addr`=addr, `mem_value`=wdata[15:0]. Grant = edge with `mem_blocked`=0; on grant capture `mem_rdata` into rdata[15:0] (loads) → HI.
- HI: same with `mem_addr`=addr+2 (32-bit wrap, 0xFFFFFFFE+2 = 0x00000000), `mem_value`=wdata[31:16]; grant captures rdata[31:16] → DONE.
- DONE: `done`=1 one cycle → IDLE. Stores leave `rdata` unchanged.
- ERR: `err`=1 one cycle → IDLE; `done` stays 0.
- Watchdog: counter clears on entering LO/HI; increments each blocked cycle; when count reaches `TIMEOUT` while still blocked → ERR, request dropped (a store may be half-written; not rolled back).
- Request outputs (`mem_read`/`mem_write`/`mem_lb`/`mem_hb`) are 0 outside LO/HI; `mem_read` and `mem_write` never both 1.
- Commands presented while `busy`=1 are ignored, not queued.

## Timing
- Reset: state IDLE, counter 0; `busy`, `done`, `err`, `mem_read`, `mem_write`, `mem_lb`, `mem_hb` = 0; `rdata`, `mem_addr`, `mem_value` = 0.
- Reset wins over every event; reset during LO/HI drops the request from the cycle after the reset edge.
- Unblocked latency: command sampled at edge N → LO in cycle N+1, HI in N+2, `done` in N+3, IDLE (accepting) in N+4. Each blocked cycle adds one.
- Request fields are stable for the whole of LO/HI regardless of `mem_blocked`.
- Timeout: half blocked from entering LO → ERR after `TIMEOUT` blocked edges; `err` visible the following cycle.
- `busy`=1 from cycle N+1 through the DONE/ERR cycle inclusive.

## Test plan
- Load 0x00000100, handler unblocked, returns 0xBEEF then 0xDEAD → `mem_addr` 0x100 then 0x102, `done` at N+3, `rdata`=0xDEADBEEF.
- Store 0x12345678 to 0x200, `mem_blocked` high 3 cycles in LO → `mem_value` 0x5678 held 4 cycles, then 0x1234 at 0x202; `done` at N+6; `mem_read` never 1.
- Load at 0x201, and separately `cmd_read`=`cmd_write`=1 at 0x300 → `err` pulse, no `mem_read`/`mem_write` activity, `done`=0.
- `TIMEOUT`=4, `mem_blocked` stuck high → `err` after 4 blocked edges in LO, requests drop, `busy` clears next cycle; a following unblocked load completes normally.
- Assert `reset` while in HI of a load → all outputs 0 the next cycle; new command afterwards completes with correct data.
- Load at 0xFFFFFFFE → second half addressed at 0x00000000.
